// File: rtl/display_arbiter.sv
// -----------------------------------------------------------------------------
// display_arbiter
//
// Shares one 3-digit sequential display controller between three requesters.
// A round-robin pointer picks the next requester in IDLE. The chosen value is
// latched and a one-cycle start pulse is sent to the controller. The block then
// waits in BUSY for the controller's completion pulse, or gives up after
// TIMEOUT BUSY cycles. An optional blank GAP follows each job before the next
// arbitration.
//
// Parameters
//   GAP_CYCLES  blank cycles between consecutive jobs (0 = none)
//   TIMEOUT     maximum BUSY cycles to wait for disp_done (2..65535)
//
// Ports
//   clk           single clock, rising edge
//   rst           synchronous, active-high reset
//   req[2:0]      level requests, held until the matching ack
//   value0..2     number to display for requester 0/1/2
//   disp_done     one-cycle completion pulse from the display controller
//   disp_trigger  one-cycle start pulse to the display controller
//   disp_value    value presented to the display controller
//   grant[2:0]    one-hot owner of the current job, zero when no job is active
//   ack[2:0]      one-cycle pulse to the served requester on completion
//   err           one-cycle pulse when a job is aborted by timeout
//   busy          high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module display_arbiter #(
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [7:0] value0,
  input  logic [7:0] value1,
  input  logic [7:0] value2,
  input  logic       disp_done,
  output logic       disp_trigger,
  output logic [7:0] disp_value,
  output logic [2:0] grant,
  output logic [2:0] ack,
  output logic       err,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam int              GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]   GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [15:0]     TO_LAST  = 16'(TIMEOUT - 1);

  // Modulo-3 increment for the round-robin pointer and the candidate order.
  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  state_t          r_state;
  logic [1:0]      r_ptr;
  logic [1:0]      r_owner;
  logic [15:0]     r_to_cnt;
  logic [GW-1:0]   r_gap_cnt;
  logic            r_trig;
  logic [7:0]      r_value;
  logic [2:0]      r_grant;
  logic [2:0]      r_ack;
  logic            r_err;
  logic            r_busy;

  logic [1:0]      w_cand1;
  logic [1:0]      w_cand2;
  logic            w_win_valid;
  logic [1:0]      w_win_idx;
  logic [7:0]      w_win_value;
  logic            w_done_ok;
  logic            w_timeout;

  // Candidates in search order: ptr, ptr+1, ptr+2 (mod 3).
  assign w_cand1 = inc3(r_ptr);
  assign w_cand2 = inc3(w_cand1);

  // NOTE: every signal written in always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_idx   = r_ptr;
    if (req[r_ptr]) begin
      w_win_valid = 1'b1;
      w_win_idx   = r_ptr;
    end else if (req[w_cand1]) begin
      w_win_valid = 1'b1;
      w_win_idx   = w_cand1;
    end else if (req[w_cand2]) begin
      w_win_valid = 1'b1;
      w_win_idx   = w_cand2;
    end
  end

  always_comb begin
    w_win_value = 8'd0;
    case (w_win_idx)
      2'd0:    w_win_value = value0;
      2'd1:    w_win_value = value1;
      2'd2:    w_win_value = value2;
      default: w_win_value = 8'd0;
    endcase
  end

  // A done pulse coincident with the start pulse belongs to a previous
  // controller operation, so it is not accepted.
  assign w_done_ok = disp_done & ~r_trig;
  assign w_timeout = (r_to_cnt == TO_LAST);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and clears every register, including the
    // latched display value, so a mid-job abort leaves no stale data visible.
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= 2'd0;
      r_owner   <= 2'd0;
      r_to_cnt  <= 16'd0;
      r_gap_cnt <= '0;
      r_trig    <= 1'b0;
      r_value   <= 8'd0;
      r_grant   <= 3'b000;
      r_ack     <= 3'b000;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      // Pulse outputs default low; the FSM raises them for a single cycle.
      r_trig <= 1'b0;
      r_ack  <= 3'b000;
      r_err  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_win_valid) begin
            r_state  <= S_BUSY;
            r_busy   <= 1'b1;
            r_owner  <= w_win_idx;
            r_grant  <= 3'b001 << w_win_idx;
            r_value  <= w_win_value;
            r_trig   <= 1'b1;
            r_to_cnt <= 16'd0;
          end
        end

        S_BUSY: begin
          if (w_done_ok || w_timeout) begin
            // Completion takes precedence over a simultaneous timeout.
            if (w_done_ok) begin
              r_ack <= r_grant;
            end else begin
              r_err <= 1'b1;
            end
            r_grant <= 3'b000;
            r_ptr   <= inc3(r_owner);
            if (GAP_CYCLES == 0) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state   <= S_GAP;
              r_gap_cnt <= GAP_LAST;
            end
          end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
          end
        end

        S_GAP: begin
          // Counter was loaded with GAP_CYCLES-1, so GAP lasts GAP_CYCLES cycles.
          if (r_gap_cnt == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_grant <= 3'b000;
        end
      endcase
    end
  end

  assign disp_trigger = r_trig;
  assign disp_value   = r_value;
  assign grant        = r_grant;
  assign ack          = r_ack;
  assign err          = r_err;
  assign busy         = r_busy;

endmodule

// File: tb/tb_display_arbiter.sv
// -----------------------------------------------------------------------------
// tb_display_arbiter
//
// Two arbiter instances share clock and reset:
//   dut_a  GAP_CYCLES=4, TIMEOUT=8     single job, timeout, collision,
//                                      value stability, reset mid-job
//   dut_b  GAP_CYCLES=0, TIMEOUT=1024  round-robin with all requests held
// Stimulus pushes the expected trigger/ack/err events into a per-instance
// queue; a negedge monitor pops and compares whenever an instance emits one.
// -----------------------------------------------------------------------------
module tb_display_arbiter;

  typedef enum logic [1:0] {EV_TRIG = 2'd0, EV_ACK = 2'd1, EV_ERR = 2'd2} ev_kind_t;
  typedef struct packed {
    ev_kind_t   kind;
    logic [2:0] bits;
    logic [7:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [2:0] a_req = '0, b_req = '0;
  logic [7:0] a_v0 = '0, a_v1 = '0, a_v2 = '0;
  logic [7:0] b_v0 = '0, b_v1 = '0, b_v2 = '0;
  logic       a_done = 1'b0, b_done = 1'b0;
  logic       a_trig, b_trig, a_err, b_err, a_busy, b_busy;
  logic [7:0] a_val, b_val;
  logic [2:0] a_grant, b_grant, a_ack, b_ack;

  ev_t q_a[$];
  ev_t q_b[$];
  int  n_checks = 0;
  int  n_errors = 0;

  display_arbiter #(.GAP_CYCLES(4), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst), .req(a_req),
    .value0(a_v0), .value1(a_v1), .value2(a_v2),
    .disp_done(a_done), .disp_trigger(a_trig), .disp_value(a_val),
    .grant(a_grant), .ack(a_ack), .err(a_err), .busy(a_busy)
  );

  display_arbiter #(.GAP_CYCLES(0), .TIMEOUT(1024)) dut_b (
    .clk(clk), .rst(rst), .req(b_req),
    .value0(b_v0), .value1(b_v1), .value2(b_v2),
    .disp_done(b_done), .disp_trigger(b_trig), .disp_value(b_val),
    .grant(b_grant), .ack(b_ack), .err(b_err), .busy(b_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input bit is_b, input ev_t got);
    ev_t exp;
    if ((is_b && q_b.size() == 0) || (!is_b && q_a.size() == 0)) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_%s_unexpected: got=%0h expected=none (t=%0t)",
               is_b ? "b" : "a", got, $time);
    end else begin
      if (is_b) exp = q_b.pop_front();
      else      exp = q_a.pop_front();
      check(is_b ? "sb_b_event" : "sb_a_event", 32'(got), 32'(exp));
    end
  endtask

  // Monitor: outputs only change at posedge, so negedge sampling is safe.
  always @(negedge clk) begin
    if (a_trig)        sb_pop(1'b0, '{EV_TRIG, a_grant, a_val});
    if (a_ack != 3'b0) sb_pop(1'b0, '{EV_ACK, a_ack, 8'd0});
    if (a_err)         sb_pop(1'b0, '{EV_ERR, 3'b000, 8'd0});
    if (b_trig)        sb_pop(1'b1, '{EV_TRIG, b_grant, b_val});
    if (b_ack != 3'b0) sb_pop(1'b1, '{EV_ACK, b_ack, 8'd0});
    if (b_err)         sb_pop(1'b1, '{EV_ERR, 3'b000, 8'd0});
    if (!$onehot0(a_grant) || !$onehot0(a_ack) || !$onehot0(b_grant) || !$onehot0(b_ack))
      check("onehot_grant_ack", 32'({a_grant, a_ack, b_grant, b_ack}), 32'(0));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_trig(input bit is_b, input string name, output int n);
    n = 0;
    while (((is_b ? b_trig : a_trig) !== 1'b1) && n < 40) begin
      tick();
      n++;
    end
    check(name, 32'(is_b ? b_trig : a_trig), 32'(1));
  endtask

  task automatic wait_idle_a(input string name);
    int n = 0;
    while (a_busy !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    check(name, 32'(a_busy), 32'(0));
  endtask

  task automatic check_a_zero(input string name);
    check(name, 32'({a_trig, a_val, a_grant, a_ack, a_err, a_busy}), 32'(0));
  endtask

  initial begin
    int n;

    // Reset state
    tick();
    tick();
    check_a_zero("reset_a_outputs");
    check("reset_b_outputs", 32'({b_trig, b_val, b_grant, b_ack, b_err, b_busy}), 32'(0));
    rst = 1'b0;

    // Single request: value 137, done 3 cycles after trigger, 4 GAP cycles
    a_v0  = 8'd137;
    a_req = 3'b001;
    q_a.push_back('{EV_TRIG, 3'b001, 8'd137});
    q_a.push_back('{EV_ACK,  3'b001, 8'd0});
    wait_trig(1'b0, "t1_trig", n);
    check("t1_value", 32'(a_val), 32'd137);
    for (int i = 0; i < 3; i++) begin
      check("t1_grant_held", 32'(a_grant), 32'(3'b001));
      tick();
    end
    check("t1_grant_held", 32'(a_grant), 32'(3'b001));
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    a_req  = 3'b000;
    check("t1_ack", 32'(a_ack), 32'(3'b001));
    check("t1_grant_cleared", 32'(a_grant), 32'(0));
    for (int i = 0; i < 4; i++) begin
      check("t1_gap_busy", 32'(a_busy), 32'(1));
      tick();
    end
    check("t1_idle_after_gap", 32'(a_busy), 32'(0));

    // Timeout: ptr=1, requester 1 never completes; requester 2 is next
    a_v1  = 8'd55;
    a_v2  = 8'd77;
    a_req = 3'b110;
    q_a.push_back('{EV_TRIG, 3'b010, 8'd55});
    q_a.push_back('{EV_ERR,  3'b000, 8'd0});
    q_a.push_back('{EV_TRIG, 3'b100, 8'd77});
    q_a.push_back('{EV_ACK,  3'b100, 8'd0});
    wait_trig(1'b0, "t2_trig", n);
    for (int i = 0; i < 7; i++) begin
      check("t2_no_early_err", 32'(a_err), 32'(0));
      tick();
    end
    check("t2_grant_cycle8", 32'(a_grant), 32'(3'b010));
    tick();
    check("t2_err", 32'(a_err), 32'(1));
    check("t2_no_ack", 32'(a_ack), 32'(0));
    check("t2_grant_cleared", 32'(a_grant), 32'(0));
    check("t2_gap_busy", 32'(a_busy), 32'(1));
    a_req = 3'b100;
    wait_trig(1'b0, "t2_next_trig", n);
    check("t2_gap_len", 32'(n), 32'd5);
    tick();
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    a_req  = 3'b000;
    wait_idle_a("t2_idle");

    // Done and timeout in the same cycle: done wins
    a_v0  = 8'd200;
    a_req = 3'b001;
    q_a.push_back('{EV_TRIG, 3'b001, 8'd200});
    q_a.push_back('{EV_ACK,  3'b001, 8'd0});
    wait_trig(1'b0, "t3_trig", n);
    for (int i = 0; i < 7; i++) tick();
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    a_req  = 3'b000;
    check("t3_ack", 32'(a_ack), 32'(3'b001));
    check("t3_err_low", 32'(a_err), 32'(0));
    wait_idle_a("t3_idle");

    // Value stability, done coincident with trigger ignored, req dropped mid-job
    a_v1  = 8'd42;
    a_req = 3'b010;
    q_a.push_back('{EV_TRIG, 3'b010, 8'd42});
    q_a.push_back('{EV_ACK,  3'b010, 8'd0});
    wait_trig(1'b0, "t4_trig", n);
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    check("t4_done_with_trig_ignored", 32'({a_ack, a_busy, a_grant}), 32'({3'b000, 1'b1, 3'b010}));
    a_v1 = 8'd99;
    tick();
    check("t4_value_stable", 32'(a_val), 32'd42);
    a_req = 3'b000;
    tick();
    check("t4_value_stable", 32'(a_val), 32'd42);
    check("t4_grant_after_req_drop", 32'(a_grant), 32'(3'b010));
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    check("t4_ack", 32'(a_ack), 32'(3'b010));
    wait_idle_a("t4_idle");

    // disp_done while IDLE is ignored
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    tick();
    check("idle_done_ignored", 32'({a_busy, a_ack, a_err}), 32'(0));

    // Reset mid-job: silent abort, ptr back to 0
    a_v0  = 8'd11;
    a_req = 3'b001;
    q_a.push_back('{EV_TRIG, 3'b001, 8'd11});
    wait_trig(1'b0, "t5_trig", n);
    tick();
    rst = 1'b1;
    tick();
    check_a_zero("t5_reset_outputs");
    rst   = 1'b0;
    a_v0  = 8'd21;
    a_v2  = 8'd23;
    a_req = 3'b101;
    q_a.push_back('{EV_TRIG, 3'b001, 8'd21});
    q_a.push_back('{EV_ACK,  3'b001, 8'd0});
    tick();
    check("t5_first_edge_trig", 32'({a_trig, a_grant}), 32'({1'b1, 3'b001}));
    tick();
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    a_req  = 3'b000;
    check("t5_ack", 32'(a_ack), 32'(3'b001));
    wait_idle_a("t5_idle");

    // Round-robin with all requests held, no GAP
    b_v0  = 8'd10;
    b_v1  = 8'd20;
    b_v2  = 8'd30;
    b_req = 3'b111;
    q_b.push_back('{EV_TRIG, 3'b001, 8'd10});
    q_b.push_back('{EV_ACK,  3'b001, 8'd0});
    q_b.push_back('{EV_TRIG, 3'b010, 8'd20});
    q_b.push_back('{EV_ACK,  3'b010, 8'd0});
    q_b.push_back('{EV_TRIG, 3'b100, 8'd30});
    q_b.push_back('{EV_ACK,  3'b100, 8'd0});
    q_b.push_back('{EV_TRIG, 3'b001, 8'd10});
    q_b.push_back('{EV_ACK,  3'b001, 8'd0});
    for (int j = 0; j < 4; j++) begin
      wait_trig(1'b1, "rr_trig", n);
      tick();
      b_done = 1'b1;
      tick();
      b_done = 1'b0;
      if (j == 3) b_req = 3'b000;
      check("rr_idle_in_ack_cycle", 32'(b_busy), 32'(0));
    end

    for (int i = 0; i < 5; i++) tick();
    check("sb_a_drained", 32'(q_a.size()), 32'(0));
    check("sb_b_drained", 32'(q_b.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
